// File: rtl/pads_ctrl_pkg.sv
// Shared types for the GPIO pad controller: register map and per-pad configuration.
package pads_ctrl_pkg;

   typedef enum logic [2:0] {
      REG_OUT_VAL  = 3'd0,
      REG_OUT_EN   = 3'd1,
      REG_PULL_UP  = 3'd2,
      REG_PULL_DN  = 3'd3,
      REG_IN_VAL   = 3'd4,
      REG_IRQ_EN   = 3'd5,
      REG_IRQ_STAT = 3'd6,
      REG_EDGE_SEL = 3'd7
   } t_padreg;

   typedef struct packed {
      logic out_val;
      logic out_en;
      logic pull_up;
      logic pull_dn;
   } t_padcfg;

endpackage

// File: rtl/pads_ctrl_pad_filter.sv
// Per-pad input conditioning: synchroniser, debounce filter and edge pulses of the filtered value.
module pad_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_in,
   output logic f,
   output logic rise_evt,
   output logic fall_evt
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CW-1:0]          cnt_r;
   logic [CW-1:0]          cnt_nxt_s;
   logic                   f_r;
   logic                   f_nxt_s;
   logic                   expire_s;
   logic                   s_s;

   assign s_s = sync_r[SYNC_STAGES-1];

   // Shift the asynchronous pad value through the synchroniser chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], pad_in};
      end
   end

   // Debounce: accept the new level only after it differs for DB_CYCLES consecutive samples
   always_comb begin
      cnt_nxt_s = cnt_r;
      f_nxt_s   = f_r;
      expire_s  = 1'b0;
      if (s_s == f_r) begin
         cnt_nxt_s = '0;
      end else if (cnt_r == CNT_LAST) begin
         f_nxt_s   = s_s;
         cnt_nxt_s = '0;
         expire_s  = 1'b1;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
   end

   // Debounce state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
         f_r   <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         f_r   <= f_nxt_s;
      end
   end

   // Events coincide with the edge that updates f, so IRQ_STAT sets together with IN_VAL
   assign f        = f_r;
   assign rise_evt = expire_s & s_s;
   assign fall_evt = expire_s & ~s_s;

endmodule

// File: rtl/pads_ctrl.sv
// GPIO pad controller: register file, read port, input filtering and level interrupt.
module pads_ctrl
   import pads_ctrl_pkg::*;
#(
   parameter int NUMPADS     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUMPADS-1:0] pad_in,
   output logic [NUMPADS-1:0] output_val,
   output logic [NUMPADS-1:0] output_en,
   output logic [NUMPADS-1:0] pullup_en,
   output logic [NUMPADS-1:0] pulldown_en,
   input  logic               reg_wr,
   input  logic               reg_rd,
   input  logic [2:0]         reg_addr,
   input  logic [NUMPADS-1:0] reg_wdata,
   output logic [NUMPADS-1:0] reg_rdata,
   output logic               reg_rvalid,
   output logic               irq
);

   t_padcfg            cfg_r     [NUMPADS];
   t_padcfg            cfg_nxt_s [NUMPADS];
   logic [NUMPADS-1:0] irq_en_r, irq_en_nxt_s;
   logic [NUMPADS-1:0] irq_stat_r, irq_stat_nxt_s;
   logic [NUMPADS-1:0] edge_sel_r, edge_sel_nxt_s;
   logic [NUMPADS-1:0] pullup_r, pullup_nxt_s;
   logic [NUMPADS-1:0] rdata_r, rd_mux_s;
   logic               rvalid_r;
   logic               irq_r;
   logic [NUMPADS-1:0] w1c_s;
   logic [NUMPADS-1:0] f_s, rise_s, fall_s, evt_s;
   logic [NUMPADS-1:0] out_val_s, out_en_s, pull_up_s, pull_dn_s;

   for (genvar g = 0; g < NUMPADS; g++) begin : g_pad
      pad_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_filter (
         .clk      (clk),
         .rst      (rst),
         .pad_in   (pad_in[g]),
         .f        (f_s[g]),
         .rise_evt (rise_s[g]),
         .fall_evt (fall_s[g])
      );
   end

   assign evt_s = (rise_s & edge_sel_r) | (fall_s & ~edge_sel_r);

   // Flatten per-pad configuration into bus-wide vectors
   always_comb begin
      for (int i = 0; i < NUMPADS; i++) begin
         out_val_s[i] = cfg_r[i].out_val;
         out_en_s[i]  = cfg_r[i].out_en;
         pull_up_s[i] = cfg_r[i].pull_up;
         pull_dn_s[i] = cfg_r[i].pull_dn;
      end
   end

   // Register write decode; IRQ_STAT is write-1-to-clear and a simultaneous event wins
   always_comb begin
      cfg_nxt_s      = cfg_r;
      irq_en_nxt_s   = irq_en_r;
      edge_sel_nxt_s = edge_sel_r;
      w1c_s          = '0;
      if (reg_wr) begin
         case (t_padreg'(reg_addr))
            REG_OUT_VAL:  for (int i = 0; i < NUMPADS; i++) cfg_nxt_s[i].out_val = reg_wdata[i];
            REG_OUT_EN:   for (int i = 0; i < NUMPADS; i++) cfg_nxt_s[i].out_en  = reg_wdata[i];
            REG_PULL_UP:  for (int i = 0; i < NUMPADS; i++) cfg_nxt_s[i].pull_up = reg_wdata[i];
            REG_PULL_DN:  for (int i = 0; i < NUMPADS; i++) cfg_nxt_s[i].pull_dn = reg_wdata[i];
            REG_IRQ_EN:   irq_en_nxt_s   = reg_wdata;
            REG_IRQ_STAT: w1c_s          = reg_wdata;
            REG_EDGE_SEL: edge_sel_nxt_s = reg_wdata;
            default:      w1c_s          = '0;
         endcase
      end else begin
         w1c_s = '0;
      end
      irq_stat_nxt_s = (irq_stat_r & ~w1c_s) | evt_s;
      for (int i = 0; i < NUMPADS; i++) begin
         pullup_nxt_s[i] = cfg_nxt_s[i].pull_up & ~cfg_nxt_s[i].pull_dn;
      end
   end

   // Read mux sees pre-write register contents
   always_comb begin
      case (t_padreg'(reg_addr))
         REG_OUT_VAL:  rd_mux_s = out_val_s;
         REG_OUT_EN:   rd_mux_s = out_en_s;
         REG_PULL_UP:  rd_mux_s = pull_up_s;
         REG_PULL_DN:  rd_mux_s = pull_dn_s;
         REG_IN_VAL:   rd_mux_s = f_s;
         REG_IRQ_EN:   rd_mux_s = irq_en_r;
         REG_IRQ_STAT: rd_mux_s = irq_stat_r;
         REG_EDGE_SEL: rd_mux_s = edge_sel_r;
         default:      rd_mux_s = '0;
      endcase
   end

   // Register file, read port and interrupt state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUMPADS; i++) cfg_r[i] <= '0;
         irq_en_r   <= '0;
         irq_stat_r <= '0;
         edge_sel_r <= '0;
         pullup_r   <= '0;
         rdata_r    <= '0;
         rvalid_r   <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         cfg_r      <= cfg_nxt_s;
         irq_en_r   <= irq_en_nxt_s;
         irq_stat_r <= irq_stat_nxt_s;
         edge_sel_r <= edge_sel_nxt_s;
         pullup_r   <= pullup_nxt_s;
         rdata_r    <= reg_rd ? rd_mux_s : '0;
         rvalid_r   <= reg_rd;
         irq_r      <= |(irq_stat_r & irq_en_r);
      end
   end

   assign output_val  = out_val_s;
   assign output_en   = out_en_s;
   assign pullup_en   = pullup_r;
   assign pulldown_en = pull_dn_s;
   assign reg_rdata   = rdata_r;
   assign reg_rvalid  = rvalid_r;
   assign irq         = irq_r;

endmodule

// File: tb/tb_pads_ctrl.sv
// Directed plus randomized bench for pads_ctrl against a sliding-window reference model.
module tb_pads_ctrl;

   localparam int NP   = 8;
   localparam int SYNC = 2;
   localparam int DB   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] pad_in, output_val, output_en, pullup_en, pulldown_en;
   logic          reg_wr, reg_rd, reg_rvalid, irq;
   logic [2:0]    reg_addr;
   logic [NP-1:0] reg_wdata, reg_rdata;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [NP-1:0] m_samp [SYNC+DB];
   logic [NP-1:0] m_f, m_outv, m_oen, m_up, m_dn, m_ien, m_stat, m_esel, m_rdata;
   logic          m_rvalid, m_irq;

   always #5 clk = ~clk;

   pads_ctrl #(.NUMPADS(NP), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .pad_in(pad_in),
      .output_val(output_val), .output_en(output_en),
      .pullup_en(pullup_en), .pulldown_en(pulldown_en),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .reg_rvalid(reg_rvalid), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < SYNC + DB; j++) m_samp[j] = '0;
      m_f = '0; m_outv = '0; m_oen = '0; m_up = '0; m_dn = '0;
      m_ien = '0; m_stat = '0; m_esel = '0; m_rdata = '0;
      m_rvalid = 1'b0; m_irq = 1'b0;
   endtask

   function automatic logic [NP-1:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return m_outv;
         3'd1: return m_oen;
         3'd2: return m_up;
         3'd3: return m_dn;
         3'd4: return m_f;
         3'd5: return m_ien;
         3'd6: return m_stat;
         default: return m_esel;
      endcase
   endfunction

   // Filtered bit flips once its last DB synchronised samples all disagree with it.
   task automatic model_edge();
      logic [NP-1:0] flip, newf, evt, w1c, rv;
      rv = reg_rd ? m_read(reg_addr) : '0;
      for (int j = SYNC + DB - 1; j > 0; j--) m_samp[j] = m_samp[j-1];
      m_samp[0] = pad_in;
      for (int b = 0; b < NP; b++) begin
         flip[b] = 1'b1;
         for (int j = SYNC; j < SYNC + DB; j++)
            if (m_samp[j][b] == m_f[b]) flip[b] = 1'b0;
      end
      newf  = m_f ^ flip;
      evt   = (flip & newf & m_esel) | (flip & ~newf & ~m_esel);
      m_irq = |(m_stat & m_ien);
      w1c   = (reg_wr && reg_addr == 3'd6) ? reg_wdata : '0;
      m_stat = (m_stat & ~w1c) | evt;
      if (reg_wr) begin
         case (reg_addr)
            3'd0: m_outv = reg_wdata;
            3'd1: m_oen  = reg_wdata;
            3'd2: m_up   = reg_wdata;
            3'd3: m_dn   = reg_wdata;
            3'd5: m_ien  = reg_wdata;
            3'd7: m_esel = reg_wdata;
            default: ;
         endcase
      end
      m_f = newf;
      m_rdata = rv;
      m_rvalid = reg_rd;
   endtask

   task automatic check_all();
      chk("output_val",  output_val,  m_outv);
      chk("output_en",   output_en,   m_oen);
      chk("pullup_en",   pullup_en,   m_up & ~m_dn);
      chk("pulldown_en", pulldown_en, m_dn);
      chk("reg_rdata",   reg_rdata,   m_rdata);
      chk("reg_rvalid",  reg_rvalid,  m_rvalid);
      chk("irq",         irq,         m_irq);
   endtask

   task automatic cyc(input bit wr, input bit rd, input logic [2:0] addr, input logic [NP-1:0] wdata);
      reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = wdata;
      model_edge();
      @(posedge clk); #1;
      check_all();
      reg_wr = 1'b0; reg_rd = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_val"},    output_val,  '0);
      chk({tag, "_en"},     output_en,   '0);
      chk({tag, "_pu"},     pullup_en,   '0);
      chk({tag, "_pd"},     pulldown_en, '0);
      chk({tag, "_rdata"},  reg_rdata,   '0);
      chk({tag, "_rvalid"}, reg_rvalid,  '0);
      chk({tag, "_irq"},    irq,         '0);
   endtask

   initial begin
      rst = 1'b0; pad_in = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 3'd0; reg_wdata = '0;
      model_reset();
      #12;
      chk_all_zero("reset");
      @(posedge clk); #1 rst = 1'b1;

      // write and read back OUT_EN
      cyc(1'b1, 1'b0, 3'd1, 8'hA5);
      chk("t1_out_en", output_en, 8'hA5);
      cyc(1'b0, 1'b1, 3'd1, 8'h00);
      chk("t1_rdata", reg_rdata, 8'hA5);
      chk("t1_rvalid", reg_rvalid, 1'b1);
      cyc(1'b0, 1'b0, 3'd0, 8'h00);
      chk("t1_rvalid_drop", reg_rvalid, 1'b0);
      chk("t1_rdata_zero", reg_rdata, 8'h00);

      // input latency, then a short glitch that must be filtered
      pad_in = 8'h01;
      for (int c = 1; c <= 8; c++) begin
         cyc(1'b0, 1'b1, 3'd4, 8'h00);
         chk("t2_in_lat", reg_rdata, (c >= 6) ? 8'h01 : 8'h00);
      end
      for (int c = 1; c <= 8; c++) begin
         pad_in = (c <= 2) ? 8'h03 : 8'h01;
         cyc(1'b0, 1'b1, 3'd4, 8'h00);
         chk("t2_glitch", reg_rdata, 8'h01);
      end

      // rising-edge interrupt on pad0
      cyc(1'b1, 1'b0, 3'd7, 8'h01);
      cyc(1'b1, 1'b0, 3'd5, 8'h01);
      pad_in = 8'h00;
      for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 3'd0, 8'h00);
      cyc(1'b0, 1'b1, 3'd6, 8'h00);
      chk("t3_fall_ignored", reg_rdata, 8'h00);
      pad_in = 8'h01;
      for (int c = 1; c <= 7; c++) begin
         cyc(1'b0, 1'b1, 3'd6, 8'h00);
         chk("t3_stat", reg_rdata, (c >= 6) ? 8'h01 : 8'h00);
         chk("t3_irq", irq, (c >= 6) ? 1'b1 : 1'b0);
      end
      cyc(1'b1, 1'b0, 3'd6, 8'h01);
      chk("t3_irq_hold", irq, 1'b1);
      cyc(1'b0, 1'b0, 3'd0, 8'h00);
      chk("t3_irq_clr", irq, 1'b0);
      pad_in = 8'h00;
      for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 3'd0, 8'h00);
      cyc(1'b0, 1'b1, 3'd6, 8'h00);
      chk("t3_fall_no_evt", reg_rdata, 8'h00);

      // W1C colliding with a new event: set wins
      pad_in = 8'h01;
      for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 3'd0, 8'h00);
      cyc(1'b1, 1'b0, 3'd6, 8'h01);
      cyc(1'b0, 1'b1, 3'd6, 8'h00);
      chk("t4_collision", reg_rdata, 8'h01);
      chk("t4_irq", irq, 1'b1);
      cyc(1'b1, 1'b0, 3'd6, 8'h01);
      cyc(1'b0, 1'b1, 3'd6, 8'h00);
      chk("t4_cleared", reg_rdata, 8'h00);
      chk("t4_irq_low", irq, 1'b0);

      // pull conflict
      cyc(1'b1, 1'b0, 3'd2, 8'hFF);
      cyc(1'b1, 1'b0, 3'd3, 8'h0F);
      chk("t5_pullup", pullup_en, 8'hF0);
      chk("t5_pulldown", pulldown_en, 8'h0F);

      // asynchronous reset in the middle of a debounce
      cyc(1'b1, 1'b0, 3'd1, 8'hFF);
      pad_in = 8'h00;
      cyc(1'b0, 1'b1, 3'd0, 8'h00);
      cyc(1'b0, 1'b1, 3'd0, 8'h00);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("t6_async");
      model_reset();
      pad_in = 8'hFF;
      @(posedge clk); @(posedge clk); #1 rst = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc(1'b0, 1'b1, 3'd4, 8'h00);
         chk("t6_in_lat", reg_rdata, (c >= 6) ? 8'hFF : 8'h00);
      end
      cyc(1'b0, 1'b1, 3'd6, 8'h00);
      chk("t6_stat", reg_rdata, 8'h00);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 5) == 0) pad_in = pad_in ^ NP'($urandom & $urandom);
         cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
             3'($urandom_range(0, 7)), NP'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
